// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan display: the active-low hex
// glyph table and the "all dark" patterns for segments and anodes.
package seg7_pkg;

    // Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup; the table already encodes active-low polarity.
    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 8-digit hex display driver with per-frame snapshot,
// optional leading-zero blanking and per-digit decimal points.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an
);

    localparam int         PCNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [PCNT_W-1:0] pcnt_reg;
    logic [2:0]        idx_reg;
    logic [2:0]        idx_next;
    logic [31:0]       snap_val_reg;
    logic [31:0]       snap_val_next;
    logic [7:0]        snap_dp_reg;
    logic [7:0]        snap_dp_next;
    logic [7:0]        an_reg;
    logic [6:0]        seg_reg;
    logic              dp_reg;
    logic              tick;
    logic              blank_slot;
    logic [3:0]        cur_nibble;
    logic [6:0]        cur_glyph;
    logic [7:0]        digit_nz;

    assign tick = (pcnt_reg == PCNT_LAST);

    // Prescaler: one tick every REFRESH_DIV cycles marks a slot boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_reg <= '0;
        end else if (tick) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_reg + 1'b1;
        end
    end

    // Next digit index and frame snapshot; the snapshot only refreshes when
    // the scan wraps to digit 0, so a frame never mixes two input words.
    always_comb begin
        idx_next      = idx_reg;
        snap_val_next = snap_val_reg;
        snap_dp_next  = snap_dp_reg;
        if (tick) begin
            idx_next = idx_reg + 3'd1;
            if (idx_reg == LAST_IDX) begin
                snap_val_next = value;
                snap_dp_next  = dp_mask;
            end
        end
    end

    // A digit is significant if it or any more-significant nibble is nonzero;
    // digit 0 is always significant so zero still shows as "0".
    assign digit_nz[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_nz
            assign digit_nz[gi] = |snap_val_next[31:4*gi];
        end
    endgenerate

    assign cur_nibble = snap_val_next[{idx_next, 2'b00} +: 4];
    assign blank_slot = blank_lz & ~digit_nz[idx_next];

    seg7_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg    (cur_glyph)
    );

    // Scan state: index and snapshot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg      <= LAST_IDX;
            snap_val_reg <= '0;
            snap_dp_reg  <= '0;
        end else begin
            idx_reg      <= idx_next;
            snap_val_reg <= snap_val_next;
            snap_dp_reg  <= snap_dp_next;
        end
    end

    // Output registers load only at slot boundaries, from the post-tick index
    // and snapshot, so anode and segments switch together on one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_reg  <= AN_OFF;
            seg_reg <= SEG_OFF;
            dp_reg  <= 1'b1;
        end else if (tick) begin
            if (blank_slot) begin
                an_reg  <= AN_OFF;
                seg_reg <= SEG_OFF;
                dp_reg  <= 1'b1;
            end else begin
                an_reg  <= ~(8'b1 << idx_next);
                seg_reg <= cur_glyph;
                dp_reg  <= ~snap_dp_next[idx_next];
            end
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign dp  = dp_reg;

endmodule
